// File: rtl/spinnaker_link_packet_gen.sv
// SpiNNaker 2-of-7 NRZ link transmitter model: emits an endless stream of
// deterministic multicast packets, advancing one symbol per acknowledge toggle.
module spinnaker_link_packet_gen #(
    parameter logic [15:0] PKT_GAP   = 16'd0,
    parameter bit          LONG_EN   = 1'b1,
    parameter logic [31:0] KEY_START = 32'h0
) (
    input  logic       clk,
    input  logic       reset,
    output logic [6:0] data_2of7,
    input  logic       ack
);

    typedef enum logic [1:0] {ST_RESET, ST_WAIT, ST_GAP} state_t;

    state_t      state_q, state_d;
    logic [6:0]  data_q, data_d;
    logic        ack_meta_q, ack_sync_q;
    logic        ack_ref_q, ack_ref_d;
    logic [31:0] pkt_q, pkt_d;
    logic [4:0]  idx_q, idx_d;
    logic [15:0] gap_q, gap_d;

    function automatic logic [6:0] nib_code(input logic [3:0] nib);
        case (nib)
            4'h0: nib_code = 7'h11;
            4'h1: nib_code = 7'h12;
            4'h2: nib_code = 7'h14;
            4'h3: nib_code = 7'h18;
            4'h4: nib_code = 7'h21;
            4'h5: nib_code = 7'h22;
            4'h6: nib_code = 7'h24;
            4'h7: nib_code = 7'h28;
            4'h8: nib_code = 7'h41;
            4'h9: nib_code = 7'h42;
            4'hA: nib_code = 7'h44;
            4'hB: nib_code = 7'h48;
            4'hC: nib_code = 7'h03;
            4'hD: nib_code = 7'h06;
            4'hE: nib_code = 7'h0C;
            default: nib_code = 7'h09;
        endcase
    endfunction

    // Index of the EOP symbol: 10 for short packets, 18 for long ones.
    function automatic logic [4:0] last_idx(input logic odd);
        last_idx = (LONG_EN && odd) ? 5'd18 : 5'd10;
    endfunction

    function automatic logic [6:0] sym_code(input logic [31:0] n, input logic [4:0] idx);
        logic [31:0] key;
        logic [31:0] pay;
        logic        lng;
        logic [7:0]  hdr;
        logic [71:0] seq;
        logic [3:0]  nib;
        key = KEY_START + n;
        lng = LONG_EN & n[0];
        pay = lng ? ~key : 32'h0;
        // Parity bit makes the total ones count over header, key and payload odd.
        hdr = {6'b0, lng, ~(^{lng, key, pay})};
        seq = {pay, key, hdr};
        nib = seq[{idx, 2'b00} +: 4];
        if (idx == last_idx(n[0])) begin
            sym_code = 7'h60;
        end else begin
            sym_code = nib_code(nib);
        end
    endfunction

    // Ack synchronizer: free-running, deliberately not reset.
    always_ff @(posedge clk) begin
        ack_meta_q <= ack;
        ack_sync_q <= ack_meta_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_RESET;
            data_q    <= 7'h00;
            ack_ref_q <= ack_sync_q;
            pkt_q     <= 32'h0;
            idx_q     <= 5'd0;
            gap_q     <= 16'd0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            ack_ref_q <= ack_ref_d;
            pkt_q     <= pkt_d;
            idx_q     <= idx_d;
            gap_q     <= gap_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        ack_ref_d = ack_ref_q;
        pkt_d     = pkt_q;
        idx_d     = idx_q;
        gap_d     = gap_q;
        case (state_q)
            ST_RESET: begin
                ack_ref_d = ack_sync_q;
                data_d    = data_q ^ sym_code(pkt_q, idx_q);
                state_d   = ST_WAIT;
            end
            ST_WAIT: begin
                if (ack_sync_q != ack_ref_q) begin
                    ack_ref_d = ack_sync_q;
                    if (idx_q == last_idx(pkt_q[0])) begin
                        pkt_d = pkt_q + 32'd1;
                        idx_d = 5'd0;
                        if (PKT_GAP == 16'd0) begin
                            data_d = data_q ^ sym_code(pkt_q + 32'd1, 5'd0);
                        end else begin
                            gap_d   = PKT_GAP - 16'd1;
                            state_d = ST_GAP;
                        end
                    end else begin
                        idx_d  = idx_q + 5'd1;
                        data_d = data_q ^ sym_code(pkt_q, idx_q + 5'd1);
                    end
                end
            end
            ST_GAP: begin
                // Acks here are protocol errors: absorb them without advancing.
                ack_ref_d = ack_sync_q;
                if (gap_q == 16'd0) begin
                    data_d  = data_q ^ sym_code(pkt_q, idx_q);
                    state_d = ST_WAIT;
                end else begin
                    gap_d = gap_q - 16'd1;
                end
            end
            default: state_d = ST_RESET;
        endcase
    end

    assign data_2of7 = data_q;

endmodule

// File: tb/tb_spinnaker_link_packet_gen.sv
// Bench for spinnaker_link_packet_gen: a responding receiver decodes the 2-of-7
// stream and checks packets, latency, inter-packet gap and mid-packet reset.
module tb_spinnaker_link_packet_gen;

    logic       clk = 1'b0;
    logic       rst_a, rst_g, ack_a, ack_g;
    logic [6:0] data_a, data_g;
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [6:0] prev [2];
    logic [6:0] codes [16] = '{7'h11, 7'h12, 7'h14, 7'h18, 7'h21, 7'h22, 7'h24, 7'h28,
                               7'h41, 7'h42, 7'h44, 7'h48, 7'h03, 7'h06, 7'h0C, 7'h09};

    typedef struct {
        int unsigned n;
        int          inject;
        logic [7:0]  hdr;
        logic [31:0] key;
        logic [31:0] pay;
        bit          lng;
    } vec_t;

    vec_t tbl [8];
    vec_t gtbl [4];

    spinnaker_link_packet_gen dut (
        .clk(clk), .reset(rst_a), .data_2of7(data_a), .ack(ack_a)
    );

    spinnaker_link_packet_gen #(
        .PKT_GAP(16'd5), .LONG_EN(1'b1), .KEY_START(32'hFFFF_FFFE)
    ) dut_gap (
        .clk(clk), .reset(rst_g), .data_2of7(data_g), .ack(ack_g)
    );

    always #5 clk = ~clk;

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached, required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
        end
    endtask

    function automatic int decode(input logic [6:0] d);
        for (int i = 0; i < 16; i++) if (d == codes[i]) return i;
        if (d == 7'h60) return 16;
        return -1;
    endfunction

    task automatic toggle(input bit sel);
        if (sel) ack_g = ~ack_g;
        else     ack_a = ~ack_a;
    endtask

    // Wait (bounded) for the next symbol; sym = -2 on timeout, -1 on bad code.
    task automatic get_sym(input bit sel, input bit do_ack, input int inject_at,
                           output int sym, output int waited);
        logic [6:0] cur;
        waited = 0;
        cur = sel ? data_g : data_a;
        while (cur == prev[sel] && waited < 60) begin
            @(negedge clk);
            waited++;
            if (inject_at > 0 && waited == inject_at) toggle(sel);
            cur = sel ? data_g : data_a;
        end
        if (cur == prev[sel]) begin
            sym = -2;
        end else begin
            sym = decode(cur ^ prev[sel]);
            prev[sel] = cur;
            if (do_ack) toggle(sel);
        end
    endtask

    task automatic get_packet(input bit sel, input int inject_at,
                              output logic [7:0] hdr, output logic [31:0] key,
                              output logic [31:0] pay, output int nsym,
                              output int first_wait, output logic [6:0] st1,
                              output bit ok, output int bad_lat);
        int s, w;
        bit eop;
        hdr = '0; key = '0; pay = '0; nsym = 0; first_wait = 0; st1 = '0;
        ok = 1'b1; bad_lat = 0; eop = 1'b0;
        for (int i = 0; i < 20; i++) begin
            get_sym(sel, 1'b1, (i == 0) ? inject_at : 0, s, w);
            if (i == 0) first_wait = w;
            else if (w != 3) bad_lat++;
            if (s < 0) begin
                ok = 1'b0;
                break;
            end
            nsym++;
            if (i == 1) st1 = prev[sel];
            if (s == 16) begin
                eop = 1'b1;
                break;
            end
            if (i < 2)       hdr[i*4 +: 4] = s[3:0];
            else if (i < 10) key[(i-2)*4 +: 4] = s[3:0];
            else if (i < 18) pay[(i-10)*4 +: 4] = s[3:0];
            else             ok = 1'b0;
        end
        if (!eop) ok = 1'b0;
    endtask

    task automatic check_pkt(input string tag, input logic [7:0] eh, input logic [31:0] ek,
                             input logic [31:0] ep, input bit el,
                             input logic [7:0] gh, input logic [31:0] gk, input logic [31:0] gp,
                             input int nsym, input bit ok, input int bad_lat);
        int ones;
        chk({tag, "_framing"}, 64'(ok), 64'(1'b1));
        chk({tag, "_hdr"}, 64'(gh), 64'(eh));
        chk({tag, "_key"}, 64'(gk), 64'(ek));
        if (el) chk({tag, "_payload"}, 64'(gp), 64'(ep));
        chk({tag, "_nsym"}, 64'(nsym), el ? 64'(19) : 64'(11));
        ones = $countones(gh) + $countones(gk) + (gh[1] ? $countones(gp) : 0);
        chk({tag, "_parity_odd"}, 64'(ones % 2), 64'(1));
        chk({tag, "_latency"}, 64'(bad_lat), 64'(0));
    endtask

    function automatic void model(input int unsigned n, input logic [31:0] kst,
                                  output logic [7:0] hdr, output logic [31:0] key,
                                  output logic [31:0] pay, output bit lng);
        int ones;
        key  = kst + n;
        lng  = n[0];
        pay  = lng ? ~key : 32'h0;
        ones = $countones(key) + (lng ? $countones(pay) : 0) + (lng ? 1 : 0);
        hdr  = {6'b0, lng, 1'((ones % 2) == 0)};
    endfunction

    initial begin
        logic [7:0]  gh, eh;
        logic [31:0] gk, gp, ek, ep;
        logic [6:0]  st1, last;
        bit          ok, el;
        int          ns, fw, bl, chg, s, w;

        tbl[0] = '{0, 0, 8'h01, 32'h0000_0000, 32'h0000_0000, 1'b0};
        tbl[1] = '{1, 0, 8'h02, 32'h0000_0001, 32'hFFFF_FFFE, 1'b1};
        tbl[2] = '{2, 0, 8'h00, 32'h0000_0002, 32'h0000_0000, 1'b0};
        tbl[3] = '{3, 0, 8'h02, 32'h0000_0003, 32'hFFFF_FFFC, 1'b1};
        tbl[4] = '{4, 0, 8'h00, 32'h0000_0004, 32'h0000_0000, 1'b0};
        tbl[5] = '{5, 0, 8'h02, 32'h0000_0005, 32'hFFFF_FFFA, 1'b1};
        tbl[6] = '{6, 0, 8'h01, 32'h0000_0006, 32'h0000_0000, 1'b0};
        tbl[7] = '{7, 0, 8'h02, 32'h0000_0007, 32'hFFFF_FFF8, 1'b1};
        gtbl[0] = '{0, 0, 8'h00, 32'hFFFF_FFFE, 32'h0000_0000, 1'b0};
        gtbl[1] = '{1, 0, 8'h02, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
        gtbl[2] = '{2, 4, 8'h01, 32'h0000_0000, 32'h0000_0000, 1'b0};
        gtbl[3] = '{3, 0, 8'h02, 32'h0000_0001, 32'hFFFF_FFFE, 1'b1};

        rst_a = 1'b1; rst_g = 1'b1; ack_a = 1'b0; ack_g = 1'b0;
        prev[0] = 7'h00; prev[1] = 7'h00;
        repeat (5) @(negedge clk);
        chk("reset_data", 64'(data_a), 64'(7'h00));

        rst_a = 1'b0;
        @(negedge clk);
        chk("first_symbol", 64'(data_a), 64'(7'h12));
        chg = 0;
        last = data_a;
        repeat (100) begin
            @(negedge clk);
            if (data_a != last) chg++;
            last = data_a;
        end
        chk("static_ack_no_change", 64'(chg), 64'(0));

        for (int i = 0; i < 8; i++) begin
            get_packet(1'b0, tbl[i].inject, gh, gk, gp, ns, fw, st1, ok, bl);
            check_pkt($sformatf("pkt%0d", tbl[i].n), tbl[i].hdr, tbl[i].key, tbl[i].pay,
                      tbl[i].lng, gh, gk, gp, ns, ok, bl);
            if (i == 0) chk("pkt0_state2", 64'(st1), 64'(7'h03));
            else        chk($sformatf("pkt%0d_b2b_latency", i), 64'(fw), 64'(3));
        end

        // Stop at the first bad packet to keep the log readable.
        for (int unsigned n = 8; n < 1000; n++) begin
            model(n, 32'h0, eh, ek, ep, el);
            get_packet(1'b0, 0, gh, gk, gp, ns, fw, st1, ok, bl);
            check_pkt($sformatf("pkt%0d", n), eh, ek, ep, el, gh, gk, gp, ns, ok, bl);
            if (n_bad != 0) break;
        end

        // Mid-packet reset at key nibble 3 of packet 4.
        rst_a = 1'b1;
        repeat (3) @(negedge clk);
        chk("rerun_reset_data", 64'(data_a), 64'(7'h00));
        rst_a = 1'b0;
        prev[0] = 7'h00;
        for (int unsigned n = 0; n < 4; n++) begin
            model(n, 32'h0, eh, ek, ep, el);
            get_packet(1'b0, 0, gh, gk, gp, ns, fw, st1, ok, bl);
            check_pkt($sformatf("rerun_pkt%0d", n), eh, ek, ep, el, gh, gk, gp, ns, ok, bl);
        end
        for (int i = 0; i < 5; i++) begin
            get_sym(1'b0, 1'b1, 0, s, w);
            if (i == 2) chk("mid_key_nib0", 64'(s), 64'(4));
        end
        get_sym(1'b0, 1'b0, 0, s, w);
        chk("mid_key_nib3", 64'(s), 64'(0));
        rst_a = 1'b1;
        @(negedge clk);
        chk("mid_reset_zero", 64'(data_a), 64'(7'h00));
        repeat (2) @(negedge clk);
        chk("mid_reset_held", 64'(data_a), 64'(7'h00));
        rst_a = 1'b0;
        prev[0] = 7'h00;
        get_packet(1'b0, 0, gh, gk, gp, ns, fw, st1, ok, bl);
        check_pkt("restart_pkt0", 8'h01, 32'h0, 32'h0, 1'b0, gh, gk, gp, ns, ok, bl);

        // Latency on the gap instance: ack toggled half a cycle before edge k.
        rst_g = 1'b0;
        @(negedge clk);
        chk("gap_first_symbol", 64'(data_g), 64'(7'h11));
        ack_g = ~ack_g;
        @(negedge clk);
        chk("lat_edge_k", 64'(data_g), 64'(7'h11));
        @(negedge clk);
        chk("lat_edge_k1", 64'(data_g), 64'(7'h11));
        @(negedge clk);
        chk("lat_edge_k2", 64'(data_g), 64'(7'h00));

        rst_g = 1'b1;
        @(negedge clk);
        chk("gap_reset_data", 64'(data_g), 64'(7'h00));
        repeat (2) @(negedge clk);
        rst_g = 1'b0;
        prev[1] = 7'h00;
        for (int i = 0; i < 4; i++) begin
            get_packet(1'b1, gtbl[i].inject, gh, gk, gp, ns, fw, st1, ok, bl);
            check_pkt($sformatf("gpkt%0d", gtbl[i].n), gtbl[i].hdr, gtbl[i].key, gtbl[i].pay,
                      gtbl[i].lng, gh, gk, gp, ns, ok, bl);
            // EOP ack accepted 3 negedges after the toggle, then 5 held cycles.
            if (i > 0) chk($sformatf("gpkt%0d_gap_wait", i), 64'(fw), 64'(8));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
